// File: rtl/mopshub_test_sequencer.sv
// MOPSHUB bench test sequencer: walks buses and ADC channels, emits 76-bit request
// frames and scores the frames the hub returns (RX, TX and back-to-back advanced tests).
module mopshub_test_sequencer #(
    parameter int N_ADC      = 32,
    parameter int TIMEOUT    = 4096,
    parameter int ADV_REPEAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [4:0]  n_buses_i,
    input  logic        sel_bus_i,
    input  logic [4:0]  bus_cnt_i,
    input  logic        sign_on_sig_i,
    input  logic        test_rx_i,
    input  logic        test_tx_i,
    input  logic        test_advanced_i,
    input  logic        rec_valid_i,
    input  logic [75:0] data_rec_uplink_i,
    input  logic [4:0]  can_rec_select_i,
    input  logic        tra_valid_i,
    input  logic [75:0] data_tra_downlink_i,
    input  logic [4:0]  can_tra_select_i,
    output logic [75:0] bus_dec_data_o,
    output logic        gen_valid_o,
    output logic [7:0]  bus_id_o,
    output logic [4:0]  adc_ch_o,
    output logic        test_rx_start_o,
    output logic        test_rx_end_o,
    output logic        test_tx_start_o,
    output logic        test_tx_end_o,
    output logic        test_advanced_end_o,
    output logic [15:0] err_cnt_o
);

    localparam int            TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [4:0]    ADC_LAST = 5'(N_ADC - 1);
    localparam logic [4:0]    ADV_LAST = 5'(ADV_REPEAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_SEND, S_WAIT, S_NEXT, S_DONE} state_t;
    typedef enum logic [1:0] {T_RX, T_TX, T_ADV} test_t;

    state_t            state_q, state_d;
    test_t             test_q, test_d;
    logic              signed_q, signed_d;
    logic              end_sent_q, end_sent_d;
    logic [4:0]        bus_q, bus_d;
    logic [4:0]        adc_q, adc_d;
    logic [4:0]        rcv_q, rcv_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [15:0]       err_q, err_d;

    logic [75:0]       cur_frame;
    logic [75:0]       exp_reply;
    logic [4:0]        exp_ch;
    logic              rx_hit, tx_hit, rx_ok, tx_ok, req_active, last_bus;
    logic              unused_rx_lsb;

    function automatic logic [75:0] make_frame(input logic [4:0] bus, input logic [4:0] ch);
        return {3'b000, bus, 12'h600 + {7'b0, bus}, 8'h40, 16'h2400, 3'b000, ch, 24'h0};
    endfunction

    function automatic logic [75:0] make_reply(input logic [4:0] bus, input logic [4:0] ch);
        return {3'b000, bus, 12'h580 + {7'b0, bus}, 8'h43, 16'h2400, 3'b000, ch, 24'h0};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Advanced replies arrive in send order, so they are matched against the receive index.
    assign exp_ch     = (test_q == T_ADV) ? rcv_q : adc_q;
    assign cur_frame  = make_frame(bus_q, adc_q);
    assign exp_reply  = make_reply(bus_q, exp_ch);
    assign rx_hit     = rec_valid_i && (can_rec_select_i == bus_q);
    assign tx_hit     = tra_valid_i && (can_tra_select_i == bus_q);
    assign rx_ok      = (data_rec_uplink_i[75:24] == exp_reply[75:24]);
    assign tx_ok      = (data_tra_downlink_i == cur_frame);
    assign last_bus   = sel_bus_i || (bus_q == n_buses_i);
    assign unused_rx_lsb = ^data_rec_uplink_i[23:0];

    always_comb begin
        case (test_q)
            T_RX:    req_active = test_rx_i;
            T_TX:    req_active = test_tx_i;
            default: req_active = test_advanced_i;
        endcase
    end

    assign gen_valid_o    = (state_q == S_SEND);
    assign bus_dec_data_o = gen_valid_o ? cur_frame : 76'h0;
    assign bus_id_o       = {3'b000, bus_q};
    assign adc_ch_o       = adc_q;
    assign err_cnt_o      = err_q;

    always_comb begin
        state_d             = state_q;
        test_d              = test_q;
        signed_d            = signed_q | sign_on_sig_i;
        end_sent_d          = end_sent_q;
        bus_d               = bus_q;
        adc_d               = adc_q;
        rcv_d               = rcv_q;
        tmr_d               = tmr_q;
        err_d               = err_q;
        test_rx_start_o     = 1'b0;
        test_rx_end_o       = 1'b0;
        test_tx_start_o     = 1'b0;
        test_tx_end_o       = 1'b0;
        test_advanced_end_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((signed_q || sign_on_sig_i) && (test_rx_i || test_tx_i || test_advanced_i)) begin
                    test_d  = test_rx_i ? T_RX : (test_tx_i ? T_TX : T_ADV);
                    state_d = S_START;
                end
            end
            S_START: begin
                test_rx_start_o = (test_q == T_RX);
                test_tx_start_o = (test_q == T_TX);
                bus_d   = sel_bus_i ? bus_cnt_i : 5'd0;
                adc_d   = 5'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                tmr_d = '0;
                rcv_d = 5'd0;
                if (test_q == T_ADV && adc_q != ADV_LAST) begin
                    adc_d = adc_q + 5'd1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((test_q == T_TX) ? tx_hit : rx_hit) begin
                    if (!((test_q == T_TX) ? tx_ok : rx_ok)) begin
                        err_d = sat_inc(err_q);
                    end
                    tmr_d = '0;
                    if (test_q == T_ADV && rcv_q != ADV_LAST) begin
                        rcv_d = rcv_q + 5'd1;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    err_d   = sat_inc(err_q);
                    state_d = S_NEXT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (test_q == T_RX && adc_q != ADC_LAST) begin
                    adc_d   = adc_q + 5'd1;
                    state_d = S_SEND;
                end else begin
                    adc_d = 5'd0;
                    if (last_bus) begin
                        end_sent_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        bus_d   = bus_q + 5'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_DONE: begin
                if (!end_sent_q) begin
                    test_rx_end_o       = (test_q == T_RX);
                    test_tx_end_o       = (test_q == T_TX);
                    test_advanced_end_o = (test_q == T_ADV);
                    end_sent_d          = 1'b1;
                end
                // Holding here until the request falls keeps a still-high level from restarting the test.
                if (!req_active) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            test_q     <= T_RX;
            signed_q   <= 1'b0;
            end_sent_q <= 1'b0;
            bus_q      <= 5'd0;
            adc_q      <= 5'd0;
            rcv_q      <= 5'd0;
            tmr_q      <= '0;
            err_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            test_q     <= test_d;
            signed_q   <= signed_d;
            end_sent_q <= end_sent_d;
            bus_q      <= bus_d;
            adc_q      <= adc_d;
            rcv_q      <= rcv_d;
            tmr_q      <= tmr_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Directed bench for mopshub_test_sequencer with a delayed echo/loopback responder.
module tb_mopshub_test_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  n_buses;
    logic        sel_bus;
    logic [4:0]  bus_cnt;
    logic        sign_on;
    logic        test_rx, test_tx, test_adv;
    logic        rec_valid = 1'b0;
    logic [75:0] data_rec = 76'h0;
    logic [4:0]  can_rec = 5'd0;
    logic        tra_valid = 1'b0;
    logic [75:0] data_tra = 76'h0;
    logic [4:0]  can_tra = 5'd0;
    logic [75:0] bus_dec_data;
    logic        gen_valid;
    logic [7:0]  bus_id;
    logic [4:0]  adc_ch;
    logic        rx_start, rx_end, tx_start, tx_end, adv_end;
    logic [15:0] err_cnt;

    int          errors = 0;
    int          checks = 0;
    int          cnt [6] = '{0, 0, 0, 0, 0, 0};
    logic [75:0] glog [256];
    int          mode = 0;
    logic        pv [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [75:0] pf [5];
    int          b, e;

    localparam logic [75:0] WRONG_MASK = {20'h0, 8'hFF, 48'h0};
    localparam logic [75:0] BAD_MASK   = {28'h0, 16'h0001, 32'h0};

    always #5 clk = ~clk;

    mopshub_test_sequencer #(.N_ADC(2), .TIMEOUT(16), .ADV_REPEAT(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .n_buses_i(n_buses), .sel_bus_i(sel_bus), .bus_cnt_i(bus_cnt),
        .sign_on_sig_i(sign_on), .test_rx_i(test_rx), .test_tx_i(test_tx), .test_advanced_i(test_adv),
        .rec_valid_i(rec_valid), .data_rec_uplink_i(data_rec), .can_rec_select_i(can_rec),
        .tra_valid_i(tra_valid), .data_tra_downlink_i(data_tra), .can_tra_select_i(can_tra),
        .bus_dec_data_o(bus_dec_data), .gen_valid_o(gen_valid), .bus_id_o(bus_id), .adc_ch_o(adc_ch),
        .test_rx_start_o(rx_start), .test_rx_end_o(rx_end), .test_tx_start_o(tx_start),
        .test_tx_end_o(tx_end), .test_advanced_end_o(adv_end), .err_cnt_o(err_cnt)
    );

    function automatic logic [75:0] frame_of(input logic [4:0] bus, input logic [4:0] ch);
        return {3'b000, bus, 12'h600 + {7'b0, bus}, 8'h40, 16'h2400, 3'b000, ch, 24'h0};
    endfunction

    // Correct hub reply to a request, with junk in the don't-care low bits.
    function automatic logic [75:0] reply_of(input logic [75:0] f);
        logic [4:0] bb;
        bb = f[72:68];
        return {3'b000, bb, 12'h580 + {7'b0, bb}, 8'h43, 16'h2400, f[31:24], 24'hABCDEF};
    endfunction

    always @(negedge clk) begin
        if (gen_valid) begin
            glog[cnt[0] % 256] <= bus_dec_data;
            cnt[0] <= cnt[0] + 1;
        end
        if (rx_start) cnt[1] <= cnt[1] + 1;
        if (rx_end)   cnt[2] <= cnt[2] + 1;
        if (tx_start) cnt[3] <= cnt[3] + 1;
        if (tx_end)   cnt[4] <= cnt[4] + 1;
        if (adv_end)  cnt[5] <= cnt[5] + 1;
    end

    // Responder: mode 1 echo, 2 TX loopback, 3 wrong-bus then echo, 4 corrupted echo.
    always @(negedge clk) begin
        rec_valid <= 1'b0;
        tra_valid <= 1'b0;
        if (mode == 3 && pv[2]) begin
            rec_valid <= 1'b1;
            can_rec   <= pf[2][72:68] + 5'd1;
            data_rec  <= reply_of(pf[2]) ^ WRONG_MASK;
        end
        if (pv[4]) begin
            case (mode)
                1, 3: begin rec_valid <= 1'b1; can_rec <= pf[4][72:68]; data_rec <= reply_of(pf[4]); end
                4:    begin rec_valid <= 1'b1; can_rec <= pf[4][72:68]; data_rec <= reply_of(pf[4]) ^ BAD_MASK; end
                2:    begin tra_valid <= 1'b1; can_tra <= pf[4][72:68]; data_tra <= pf[4]; end
                default: ;
            endcase
        end
        pv[0] <= gen_valid;
        pf[0] <= bus_dec_data;
        for (int i = 1; i < 5; i++) begin
            pv[i] <= pv[i-1];
            pf[i] <= pf[i-1];
        end
    end

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int idx, input int target, input int maxc, input string tag);
        int k;
        k = 0;
        while (cnt[idx] < target && k < maxc) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 76'(cnt[idx] >= target), 76'd1);
    endtask

    initial begin
        rst_n = 1'b0; sign_on = 1'b0; test_rx = 1'b0; test_tx = 1'b0; test_adv = 1'b0;
        n_buses = 5'd1; sel_bus = 1'b0; bus_cnt = 5'd0;
        tick(3);
        check("rst_gen_valid", 76'(gen_valid), 76'd0);
        check("rst_frame", bus_dec_data, 76'h0);
        check("rst_bus_adc", 76'({bus_id, adc_ch}), 76'd0);
        check("rst_err", 76'(err_cnt), 76'd0);
        check("rst_pulses", 76'({rx_start, rx_end, tx_start, tx_end, adv_end}), 76'd0);
        rst_n = 1'b1;
        tick(2);

        test_rx = 1'b1;
        tick(20);
        check("nosign_gen", 76'(cnt[0]), 76'd0);
        check("nosign_start", 76'(cnt[1]), 76'd0);
        test_rx = 1'b0;
        tick(2);

        // Short sign-on pulse must be remembered.
        sign_on = 1'b1; tick(1); sign_on = 1'b0; tick(1);
        mode = 1; b = cnt[0]; test_rx = 1'b1;
        wait_cnt(2, 1, 300, "rx_end_seen");
        check("rx_start_cnt", 76'(cnt[1]), 76'd1);
        check("rx_frames", 76'(cnt[0] - b), 76'd4);
        check("rx_err", 76'(err_cnt), 76'd0);
        check("rx_frame_b0c0", glog[b % 256], {8'h00, 12'h600, 8'h40, 16'h2400, 8'h00, 24'h0});
        check("rx_frame_b1c1", glog[(b + 3) % 256], {8'h01, 12'h601, 8'h40, 16'h2400, 8'h01, 24'h0});
        tick(6);
        check("rx_hold_frames", 76'(cnt[0] - b), 76'd4);
        check("rx_hold_end", 76'(cnt[2]), 76'd1);
        test_rx = 1'b0;
        tick(3);

        sel_bus = 1'b1; bus_cnt = 5'd7; mode = 2; b = cnt[0]; test_tx = 1'b1;
        wait_cnt(4, 1, 100, "tx_end_seen");
        check("tx_bus_id", 76'(bus_id), 76'h07);
        check("tx_frames", 76'(cnt[0] - b), 76'd1);
        check("tx_frame", glog[b % 256], {8'h07, 12'h607, 8'h40, 16'h2400, 8'h00, 24'h0});
        check("tx_start_cnt", 76'(cnt[3]), 76'd1);
        check("tx_err", 76'(err_cnt), 76'd0);
        test_tx = 1'b0; sel_bus = 1'b0;
        tick(3);

        mode = 0; n_buses = 5'd1; b = cnt[0]; test_rx = 1'b1;
        wait_cnt(2, 2, 400, "to_end_seen");
        check("to_err", 76'(err_cnt), 76'd4);
        check("to_frames", 76'(cnt[0] - b), 76'd4);
        test_rx = 1'b0;
        tick(3);

        // Both requests high: RX wins; wrong-bus replies are ignored.
        mode = 3; n_buses = 5'd0; b = cnt[0]; test_rx = 1'b1; test_tx = 1'b1;
        wait_cnt(2, 3, 200, "wb_end_seen");
        check("wb_err", 76'(err_cnt), 76'd4);
        check("wb_rx_start", 76'(cnt[1]), 76'd3);
        check("wb_tx_start", 76'(cnt[3]), 76'd1);
        check("wb_frames", 76'(cnt[0] - b), 76'd2);
        test_rx = 1'b0; test_tx = 1'b0;
        tick(3);

        mode = 4; test_rx = 1'b1;
        wait_cnt(2, 4, 200, "bad_end_seen");
        check("bad_err", 76'(err_cnt), 76'd6);
        test_rx = 1'b0;
        tick(3);

        mode = 1; n_buses = 5'd1; b = cnt[0]; test_adv = 1'b1;
        wait_cnt(5, 1, 300, "adv_end_seen");
        check("adv_frames", 76'(cnt[0] - b), 76'd8);
        check("adv_err", 76'(err_cnt), 76'd6);
        check("adv_frame_b0c3", glog[(b + 3) % 256], {8'h00, 12'h600, 8'h40, 16'h2400, 8'h03, 24'h0});
        check("adv_frame_b1c0", glog[(b + 4) % 256], {8'h01, 12'h601, 8'h40, 16'h2400, 8'h00, 24'h0});
        test_adv = 1'b0;
        tick(3);

        mode = 0; b = cnt[0]; test_rx = 1'b1;
        wait_cnt(0, b + 1, 50, "mid_first_send");
        tick(3);
        e = cnt[2];
        rst_n = 1'b0;
        #1;
        check("mid_rst_err", 76'(err_cnt), 76'd0);
        check("mid_rst_out", 76'({gen_valid, bus_id, adc_ch}), 76'd0);
        test_rx = 1'b0;
        tick(4);
        check("mid_rst_no_end", 76'(cnt[2]), 76'(e));
        rst_n = 1'b1;
        tick(2);

        mode = 1; n_buses = 5'd0; sign_on = 1'b1; b = cnt[0]; test_rx = 1'b1;
        wait_cnt(2, e + 1, 200, "restart_end_seen");
        check("restart_err", 76'(err_cnt), 76'd0);
        check("restart_frames", 76'(cnt[0] - b), 76'd2);
        test_rx = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
